// File: rtl/carry_select_seq_add32.sv
// Sequential wide adder: one 8-bit carry-select slice reused per cycle, LSB slice first,
// with valid/ready handshakes on the operand and result sides.

module carry_select_adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [4:0] w_lo;
    logic [4:0] w_hi0;
    logic [4:0] w_hi1;

    // Upper nibble is precomputed for both carry-ins; the low nibble's carry picks one.
    assign w_lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
    assign w_hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    assign w_hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

    assign sum  = {(w_lo[4] ? w_hi1[3:0] : w_hi0[3:0]), w_lo[3:0]};
    assign cout = w_lo[4] ? w_hi1[4] : w_hi0[4];
endmodule

module carry_select_seq_add32 #(
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*WORDS-1:0]   in_a,
    input  logic [8*WORDS-1:0]   in_b,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WORDS-1:0]   out_sum,
    output logic                 out_cout,
    output logic                 busy
);
    localparam int unsigned W    = 8 * WORDS;
    localparam int unsigned IDXW = $clog2(WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic            r_c;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_sum;
    logic            r_cout;

    logic [7:0]      w_a_slice;
    logic [7:0]      w_b_slice;
    logic [7:0]      w_slice_sum;
    logic            w_slice_cout;

    assign w_a_slice = r_op_a[{r_idx, 3'b000} +: 8];
    assign w_b_slice = r_op_b[{r_idx, 3'b000} +: 8];

    carry_select_adder8 u_slice (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .cin  (r_c),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)          w_next = S_ADD;
            S_ADD:   if (r_idx == LAST_IDX) w_next = S_DONE;
            S_DONE:  if (out_ready)         w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_c    <= 1'b0;
            r_idx  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op_a <= in_a;
                        r_op_b <= in_b;
                        r_c    <= in_cin;
                        r_idx  <= '0;
                    end
                end
                S_ADD: begin
                    r_sum[{r_idx, 3'b000} +: 8] <= w_slice_sum;
                    r_c                         <= w_slice_cout;
                    // Index holds on the last slice so it never wraps inside a transaction.
                    if (r_idx == LAST_IDX) begin
                        r_cout <= w_slice_cout;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_ADD) || (r_state == S_DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
endmodule

// File: tb/tb_carry_select_seq_add32.sv
// Directed bench for carry_select_seq_add32 (WORDS = 4): latency/handshake model plus
// hand-computed sums, backpressure, mid-transaction reset and back-to-back traffic.

module tb_carry_select_seq_add32;
    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    carry_select_seq_add32 #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Model: age counts edges since accept; results are plain 33-bit sums in a queue.
    int           m_age = -1;
    int           m_cyc = 0;
    int           m_nacc = 0;
    int           m_ngot = 0;
    logic [W:0]   m_q[$];
    int           m_acc_cyc[$];
    logic [W:0]   m_got[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age = -1;
            m_q.delete();
        end else begin
            m_cyc++;
            if (m_age < 0) begin
                if (in_valid) begin
                    m_q.push_back({1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin});
                    m_acc_cyc.push_back(m_cyc);
                    m_nacc++;
                    m_age = 0;
                end
            end else if (m_age < WORDS) begin
                m_age++;
            end else if (out_ready) begin
                m_got.push_back({out_cout, out_sum});
                m_ngot++;
                if (m_q.size() > 0) void'(m_q.pop_front());
                m_age = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_out_sum", out_sum, 0);
            chk("rst_out_cout", out_cout, 0);
        end else begin
            chk("m_in_ready", in_ready, (m_age < 0));
            chk("m_out_valid", out_valid, (m_age >= WORDS));
            chk("m_busy", busy, (m_age >= 0));
            if (m_age >= WORDS && m_q.size() > 0) begin
                chk("m_out_sum", out_sum, m_q[0][W-1:0]);
                chk("m_out_cout", out_cout, m_q[0][W]);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge after the accept edge; returns edges after accept until out_valid.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        if (!out_valid) begin
            n_checks++;
            $display("FAIL wait_valid: out_valid got 0 after %0d edges, required 1", edges);
        end
    endtask

    task automatic finish_txn();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("after_done_in_ready", in_ready, 1);
        chk("after_done_out_valid", out_valid, 0);
    endtask

    task automatic run_txn(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout);
        int edges;
        send(a, b, cin);
        wait_valid(edges);
        chk({name, "_latency"}, edges + 1, WORDS + 1);
        chk({name, "_sum"}, out_sum, exp_sum);
        chk({name, "_cout"}, out_cout, exp_cout);
        finish_txn();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int          edges;
        int          busy_low;
        int          base_acc;
        int          base_got;
        logic [3:0]  exp_c;

        #2;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_out_sum", out_sum, 0);
        chk("reset_out_cout", out_cout, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("carry_top", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);

        // Slice carries after each ADD edge: 1, 1, 0, 0.
        exp_c = 4'b0011;
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        for (int k = 0; k < WORDS; k++) begin
            @(negedge clk);
            chk("mixed_slice_carry", dut.r_c, exp_c[k]);
        end
        chk("mixed_valid", out_valid, 1);
        chk("mixed_sum", out_sum, 32'hACF1_3569);
        chk("mixed_cout", out_cout, 0);
        finish_txn();

        run_txn("ripple", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0);

        send(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_valid(edges);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_sum", out_sum, 32'h0000_0100);
            chk("bp_out_cout", out_cout, 0);
            chk("bp_in_ready", in_ready, 0);
            if (i == 2) begin
                in_valid = 1'b1; in_a = 32'hAAAA_AAAA; in_b = 32'h5555_5555; in_cin = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_still_valid", out_valid, 1);
        chk("bp_sum_kept", out_sum, 32'h0000_0100);
        finish_txn();

        send(32'h1111_1111, 32'h2222_2222, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", in_ready, 1);
        chk("postrst_out_valid", out_valid, 0);
        run_txn("postrst", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0);

        base_acc = m_nacc;
        base_got = m_ngot;
        @(negedge clk);
        out_ready = 1'b1;
        in_a = 32'h0000_FFFF; in_b = 32'h0000_0001; in_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_first_accept", m_nacc, base_acc + 1);
        in_a = 32'h8000_0000; in_b = 32'h8000_0000; in_cin = 1'b1;
        busy_low = 0;
        for (int i = 0; i < 30 && m_nacc < base_acc + 2; i++) begin
            @(negedge clk);
            if (busy === 1'b0) busy_low++;
        end
        in_valid = 1'b0;
        chk("b2b_second_accept", m_nacc, base_acc + 2);
        chk("b2b_interval", m_acc_cyc[base_acc + 1] - m_acc_cyc[base_acc], WORDS + 2);
        chk("b2b_busy_low", busy_low, 1);
        for (int i = 0; i < 30 && m_ngot < base_got + 2; i++) @(negedge clk);
        chk("b2b_results", m_ngot, base_got + 2);
        if (m_ngot >= base_got + 2) begin
            chk("b2b_res0", m_got[base_got], {1'b0, 32'h0001_0000});
            chk("b2b_res1", m_got[base_got + 1], {1'b1, 32'h0000_0001});
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("end_in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
